spi_sample_master: RTL and testbench
====================================

Name: spi_sample_master

Overview:
- SPI master: the initiating end of the sample link whose slave shifts data in on sck rising edges and drives sdi on sck falling edges.
- Generates sck from the system clock and sends one WIDTH-bit word MSB-first on sdo. Simultaneously captures WIDTH bits from sdi.
- Used to carry 10-bit voltage samples (zero-extended into the word) and to read back filter results.
- A start/busy/done handshake connects it to the sampling and filter logic.

Parameters:
- WIDTH, 32: bits per transfer; matches the slave's 5-bit frame counter.
- CLK_DIV, 4: clk cycles per sck half-period; legal values are 1 and above.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- start  in  1  request a transfer; sampled only in IDLE.
- d  in  WIDTH  word to send; latched on the accepting cycle.
- sdi  in  1  serial data from the slave.
- sck  out  1  serial clock; idles low.
- sdo  out  1  serial data to the slave.
- q  out  WIDTH  last received word.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when q updates.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sck=0, sdo=0, busy=0, done=0, q=0; divider and bit counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - tx_sr<=d, sdo<=d[WIDTH-1].
  - div_cnt<=0, bit_cnt<=0, sck stays 0.
  - Next state SHIFT.
- SHIFT, divider: div_cnt counts 0..CLK_DIV-1. When it reaches CLK_DIV-1 it wraps to 0 and sck toggles.
- SHIFT, rising toggle (sck 0->1): rx_sr<={rx_sr[WIDTH-2:0], sdi}, sampled in the same clk cycle as the toggle.
- SHIFT, falling toggle (sck 1->0):
  - If bit_cnt==WIDTH-1, next state is DONE.
  - Otherwise tx_sr shifts left, sdo<=next MSB, bit_cnt++.
  - sdo therefore changes only with the falling edge, giving the slave a full half-period of setup.
- DONE: q<=rx_sr, done=1 for exactly this cycle, busy=0, next state IDLE.
- start is ignored in SHIFT and DONE. d changes after acceptance have no effect.
- Timing, with the accepting edge counted as cycle 0:
  - First sck rise at cycle CLK_DIV.
  - Last sck fall at cycle 2*WIDTH*CLK_DIV.
  - done high in cycle 2*WIDTH*CLK_DIV+1.
- Each transfer is exactly WIDTH sck pulses; sck is low on entry to and exit from SHIFT.
- Back-to-back: with start held high, the next transfer is accepted in the IDLE cycle after DONE. busy is low for exactly 2 cycles between transfers.
- Reset mid-transfer: all outputs go to their reset values immediately. A partial frame is discarded and q is not updated. The far end resynchronises via its own reset.
- Widths: bit_cnt is $clog2(WIDTH) bits and div_cnt is $clog2(CLK_DIV)+1 bits; neither wraps outside its stated range.

Optional Feature:
- Macro: SPI_SAMPLE_MASTER_CS_EN.
- Defined: adds output cs_n (1 bit, active-low).
  - cs_n=1 at reset and in IDLE.
  - cs_n goes 0 on the accepting cycle and stays 0 through SHIFT.
  - cs_n returns to 1 in the DONE cycle.
- Not defined: no cs_n port; frames are delimited only by the sck pulse count and reset.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t.
  - localparam SPI_WORD_W=32.
  - localparam SAMPLE_W=10.
- Sub-module spi_sck_gen: the divider. It takes clk, reset, an enable, and CLK_DIV, and outputs sck, rise_stb and fall_stb. The parent uses the strobes for shifting and sampling.

Test Plan:
- Loopback, CLK_DIV=2, d=32'hA5A5_0F0F, sdi=sdo -> q=32'hA5A5_0F0F; exactly 32 sck rises; done pulse at cycle 129, width 1.
- sdi tied 1, d=0 -> sdo=0 throughout; q=32'hFFFF_FFFF; busy high for 128 cycles.
- Behavioural slave driving sdi on sck negedge from a preload of 32'h0000_03FF -> q=32'h0000_03FF. The slave captures d=32'h0000_0155 and its voltage[9:0]=10'h155.
- start pulsed mid-transfer with d=32'h1234_5678 -> ignored; the original word completes unchanged with exactly 32 pulses.
- reset=0 at bit 10 -> sck, sdo, busy, done and q are 0 within the same cycle, with no done pulse. After release, start with d=32'hDEAD_BEEF -> a clean 32-bit transfer.
- start held high, CLK_DIV=1 -> consecutive transfers with busy low for exactly 2 cycles between them. With SPI_SAMPLE_MASTER_CS_EN defined, cs_n is high only in the DONE and IDLE cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding and widths for the SPI sample link.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;

  localparam int unsigned SPI_WORD_W = 32;
  localparam int unsigned SAMPLE_W   = 10;

  // Zero-extend a voltage sample into a full link word.
  function automatic logic [SPI_WORD_W-1:0] sample_to_word(input logic [SAMPLE_W-1:0] s);
    return SPI_WORD_W'(s);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// sck divider: sck toggles every CLK_DIV clk cycles while enabled, idles low.
// The strobes flag the clk cycle on which sck is about to rise or fall.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_c,
  output logic fall_stb_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             wrap_c;

  always_comb begin
    div_cnt_d = '0;
    sck_d     = 1'b0;
    wrap_c    = 1'b0;
    if (en_i) begin
      wrap_c    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
      div_cnt_d = wrap_c ? '0 : div_cnt_q + DIV_W'(1);
      sck_d     = wrap_c ? ~sck_q : sck_q;
    end
  end

  assign rise_stb_c = wrap_c & ~sck_q;
  assign fall_stb_c = wrap_c & sck_q;
  assign sck_o      = sck_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

endmodule

// File: rtl/spi_sample_master.sv
// SPI master for the sample link: one WIDTH-bit MSB-first full-duplex transfer per start.
// Define SPI_SAMPLE_MASTER_CS_EN to add an active-low chip select output cs_n.
module spi_sample_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = SPI_WORD_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             sdi,
  output logic             sck,
  output logic             sdo,
  output logic [WIDTH-1:0] q,
  output logic             busy,
`ifdef SPI_SAMPLE_MASTER_CS_EN
  output logic             cs_n,
`endif
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(WIDTH);

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_en_c, rise_stb_c, fall_stb_c;

  assign shift_en_c = (state_q == SHIFT);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .en_i      (shift_en_c),
    .sck_o     (sck),
    .rise_stb_c(rise_stb_c),
    .fall_stb_c(fall_stb_c)
  );

  // Sample on sck rise, advance sdo on sck fall so the slave gets a full half-period of setup.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    q_d       = q_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = d;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_stb_c) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], sdi};
        end
        if (fall_stb_c) begin
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      DONE: begin
        q_d     = rx_sr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      q_q       <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      q_q       <= q_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sdo  = tx_sr_q[WIDTH-1];
  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SPI_SAMPLE_MASTER_CS_EN
  // Chip select frames exactly the SHIFT interval, so it tracks the next busy value.
  logic cs_n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_n_q <= 1'b1;
    end else begin
      cs_n_q <= ~busy_d;
    end
  end

  assign cs_n = cs_n_q;
`endif

endmodule

// File: tb/tb_spi_sample_master.sv
// Bench for spi_sample_master: cycle-level timing model plus directed literal checks.
// Instance 0 runs CLK_DIV=2, instance 1 runs CLK_DIV=1 in loopback.
module tb_spi_sample_master;
  import spi_pkg::*;

  localparam int unsigned W = SPI_WORD_W;

  logic         clk;
  logic         rst;
  logic         start0, start1;
  logic [W-1:0] d0, d1;
  logic         sdi0, sdi1;
  logic         sck0, sck1, sdo0, sdo1, busy0, busy1, done0, done1;
  logic [W-1:0] q0, q1;
`ifdef SPI_SAMPLE_MASTER_CS_EN
  logic         cs_n0, cs_n1;
`endif

  int           sdi_mode;  // 0: zero, 1: one, 2: loopback, 3: behavioural slave
  logic         s_clr;
  logic [W-1:0] s_pre, s_tx, s_rx;
  int           n_rise = 0;

  int n_vec = 0;
  int n_err = 0;

  // Timing model state, one slot per instance.
  logic         m_in[2];
  int           m_k[2];
  logic [W-1:0] m_word[2], m_rx[2], m_q[2];

  int           x_done_cyc, x_done_cnt, x_busy_cnt, x_sdo_hi, x_rises;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sdi0 = (sdi_mode == 0) ? 1'b0 :
                (sdi_mode == 1) ? 1'b1 :
                (sdi_mode == 2) ? sdo0 : s_tx[W-1];
  assign sdi1 = sdo1;

  spi_sample_master #(.WIDTH(W), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .reset(rst), .start(start0), .d(d0), .sdi(sdi0),
    .sck(sck0), .sdo(sdo0), .q(q0), .busy(busy0),
`ifdef SPI_SAMPLE_MASTER_CS_EN
    .cs_n(cs_n0),
`endif
    .done(done0)
  );

  spi_sample_master #(.WIDTH(W), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(start1), .d(d1), .sdi(sdi1),
    .sck(sck1), .sdo(sdo1), .q(q1), .busy(busy1),
`ifdef SPI_SAMPLE_MASTER_CS_EN
    .cs_n(cs_n1),
`endif
    .done(done1)
  );

  // Mode-0 slave: drives sdi from its preload on sck falls, captures sdo on sck rises.
  always @(posedge sck0 or negedge sck0 or posedge s_clr) begin
    if (s_clr) begin
      s_tx <= s_pre;
      s_rx <= '0;
    end else if (sck0) begin
      s_rx <= {s_rx[W-2:0], sdo0};
    end else begin
      s_tx <= {s_tx[W-2:0], 1'b0};
    end
  end

  always @(posedge sck0) n_rise <= n_rise + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow from edge count k since acceptance: half-periods of C cycles,
  // one bit per 2C cycles, DONE at k=2WC, done pulse at k=2WC+1.
  task automatic compare_loop();
    logic         s_start[2];
    logic [W-1:0] s_d[2];
    logic         s_sdi[2];
    logic         o_sck[2], o_sdo[2], o_busy[2], o_done[2];
    logic [W-1:0] o_q[2];
`ifdef SPI_SAMPLE_MASTER_CS_EN
    logic         o_csn[2];
`endif
    int           c, last, bidx;
    logic         idle, e_busy, e_sck, e_done, e_sdo;
    forever begin
      @(posedge clk);
      s_start[0] = start0; s_start[1] = start1;
      s_d[0]     = d0;     s_d[1]     = d1;
      s_sdi[0]   = sdi0;   s_sdi[1]   = sdi1;
      for (int i = 0; i < 2; i++) begin
        c    = (i == 0) ? 2 : 1;
        last = 2 * int'(W) * c;
        if (!rst) begin
          m_in[i] = 1'b0; m_k[i] = 0; m_q[i] = '0; m_rx[i] = '0; m_word[i] = '0;
        end else begin
          idle = !m_in[i] || (m_k[i] >= last + 1);
          if (idle && s_start[i]) begin
            m_in[i] = 1'b1; m_k[i] = 0; m_word[i] = s_d[i];
          end else if (m_in[i] && m_k[i] < 100000) begin
            m_k[i]++;
            if (m_k[i] < last && (m_k[i] % (2 * c)) == c) m_rx[i] = {m_rx[i][W-2:0], s_sdi[i]};
            if (m_k[i] == last + 1) m_q[i] = m_rx[i];
          end
        end
      end
      #1;
      o_sck[0] = sck0;   o_sck[1] = sck1;
      o_sdo[0] = sdo0;   o_sdo[1] = sdo1;
      o_busy[0] = busy0; o_busy[1] = busy1;
      o_done[0] = done0; o_done[1] = done1;
      o_q[0] = q0;       o_q[1] = q1;
`ifdef SPI_SAMPLE_MASTER_CS_EN
      o_csn[0] = cs_n0;  o_csn[1] = cs_n1;
`endif
      for (int i = 0; i < 2; i++) begin
        c      = (i == 0) ? 2 : 1;
        last   = 2 * int'(W) * c;
        e_busy = m_in[i] && (m_k[i] < last);
        e_sck  = m_in[i] && (m_k[i] <= last) && (((m_k[i] / c) % 2) == 1);
        e_done = m_in[i] && (m_k[i] == last + 1);
        bidx   = m_k[i] / (2 * c);
        if (bidx > int'(W) - 1) bidx = int'(W) - 1;
        e_sdo  = m_in[i] ? m_word[i][int'(W) - 1 - bidx] : 1'b0;
        chk($sformatf("sck%0d", i),  32'(o_sck[i]),  32'(e_sck));
        chk($sformatf("sdo%0d", i),  32'(o_sdo[i]),  32'(e_sdo));
        chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(e_busy));
        chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done));
        chk($sformatf("q%0d", i),    o_q[i],         m_q[i]);
`ifdef SPI_SAMPLE_MASTER_CS_EN
        chk($sformatf("cs_n%0d", i), 32'(o_csn[i]),  32'(!e_busy));
`endif
      end
    end
  endtask

  // One transfer on instance 0; cycle 0 is the accepting edge.
  task automatic xfer0(input logic [W-1:0] word, input int mode, input int pulse_at);
    int base;
    sdi_mode   = mode;
    d0         = word;
    start0     = 1'b1;
    base       = n_rise;
    x_done_cyc = -1; x_done_cnt = 0; x_busy_cnt = 0; x_sdo_hi = 0;
    @(posedge clk); #1;
    start0 = 1'b0;
    d0     = ~word;
    if (busy0) x_busy_cnt++;
    if (sdo0)  x_sdo_hi++;
    for (int c = 1; c <= 2 * int'(W) * 2 + 10; c++) begin
      @(posedge clk); #1;
      if (c == pulse_at) begin
        start0 = 1'b1;
        d0     = 32'h1234_5678;
      end
      if (c == pulse_at + 1) start0 = 1'b0;
      if (done0) begin
        if (x_done_cyc < 0) x_done_cyc = c;
        x_done_cnt++;
      end
      if (busy0) x_busy_cnt++;
      if (sdo0)  x_sdo_hi++;
    end
    x_rises = n_rise - base;
  endtask

  initial begin
    int           seen, run, gaps, done_seen, cs_bad;
    logic [SAMPLE_W-1:0] volt;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; d0 = '0; d1 = '0;
    sdi_mode = 0; s_clr = 1'b0; s_pre = '0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck",  32'(sck0),  0);
    chk("rst_sdo",  32'(sdo0),  0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_q",    q0,         0);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Loopback with CLK_DIV=2.
    xfer0(32'hA5A5_0F0F, 2, -1);
    chk("t1_q",          q0,          32'hA5A5_0F0F);
    chk("t1_done_cycle", x_done_cyc,  129);
    chk("t1_done_width", x_done_cnt,  1);
    chk("t1_sck_rises",  x_rises,     32);
    chk("t1_busy_len",   x_busy_cnt,  128);

    // sdi tied high, all-zero word.
    xfer0(32'h0000_0000, 1, -1);
    chk("t2_q",        q0,         32'hFFFF_FFFF);
    chk("t2_busy_len", x_busy_cnt, 128);
    chk("t2_sdo_high", x_sdo_hi,   0);

    // Behavioural slave exchanging a sample.
    s_pre = 32'h0000_03FF;
    s_clr = 1'b1;
    #1 s_clr = 1'b0;
    xfer0(sample_to_word(10'h155), 3, -1);
    volt = s_rx[SAMPLE_W-1:0];
    chk("t3_q",        q0,          32'h0000_03FF);
    chk("t3_slave_rx", s_rx,        32'h0000_0155);
    chk("t3_voltage",  32'(volt),   32'h0000_0155);

    // start pulsed mid-transfer must be ignored.
    xfer0(32'hCAFE_F00D, 2, 40);
    chk("t4_q",          q0,         32'hCAFE_F00D);
    chk("t4_sck_rises",  x_rises,    32);
    chk("t4_done_width", x_done_cnt, 1);

    // Reset at bit 10 of an all-ones loopback transfer.
    sdi_mode = 2;
    d0       = 32'hFFFF_FFFF;
    start0   = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (42) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_sck",  32'(sck0),  0);
    chk("t5_sdo",  32'(sdo0),  0);
    chk("t5_busy", 32'(busy0), 0);
    chk("t5_done", 32'(done0), 0);
    chk("t5_q",    q0,         0);
    done_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done0) done_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_q_after", q0, 0);
    xfer0(32'hDEAD_BEEF, 2, -1);
    chk("t5_clean_q",     q0,         32'hDEAD_BEEF);
    chk("t5_clean_rises", x_rises,    32);
    chk("t5_clean_done",  x_done_cyc, 129);

    // Back-to-back transfers on the CLK_DIV=1 instance.
    d1     = 32'h0F0F_1234;
    start1 = 1'b1;
    seen = 0; run = 0; gaps = 0; cs_bad = 0;
    for (int c = 0; c <= 250; c++) begin
      @(posedge clk); #1;
`ifdef SPI_SAMPLE_MASTER_CS_EN
      if (cs_n1 === busy1) cs_bad++;
`endif
      if (busy1) begin
        if (seen != 0 && run > 0) begin
          chk("t6_gap", run, 2);
          gaps++;
        end
        seen = 1;
        run  = 0;
      end else if (seen != 0) begin
        run++;
      end
    end
    start1 = 1'b0;
    chk("t6_gap_count", gaps, 3);
    repeat (80) @(posedge clk);
    #1;
    chk("t6_q", q1, 32'h0F0F_1234);
`ifdef SPI_SAMPLE_MASTER_CS_EN
    chk("t6_cs_n", cs_bad, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
